// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the inst and data masters, tracking
// response ownership in an in-order tag FIFO. Define ARB_RR_EN for round-robin grants.
module sram_like_arbiter #(
  parameter int OT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);
  localparam int PW = $clog2(OT_DEPTH);
  localparam logic INST = 1'b0;
  localparam logic DATA = 1'b1;

  logic [PW-1:0]       wptr_q, rptr_q;
  logic [PW:0]         cnt_q, cnt_d;
  logic [OT_DEPTH-1:0] tag_q;
  logic                lock_q, lock_d, owner_q, owner_d, err_q, err_d;
  logic                full, empty, gnt, gnt_en, push, pop, head;
`ifdef ARB_RR_EN
  logic                last_q, last_d;
`endif

  always_comb begin
    full  = (cnt_q == (PW+1)'(OT_DEPTH));
    empty = (cnt_q == '0);
    if (lock_q)
      gnt = owner_q;
    else if (data_sram_en && inst_sram_en)
`ifdef ARB_RR_EN
      gnt = ~last_q;
`else
      gnt = DATA;
`endif
    else
      gnt = data_sram_en ? DATA : INST;
    gnt_en = gnt ? data_sram_en : inst_sram_en;
    // Outputs are forced low while reset is held, not just after the next edge.
    mem_en = gnt_en & ~full & ~reset;
  end

  assign mem_wr    = mem_en & (gnt ? data_sram_wr : inst_sram_wr);
  assign mem_size  = mem_en ? (gnt ? data_sram_size  : inst_sram_size)  : 2'd0;
  assign mem_wen   = mem_en ? (gnt ? data_sram_wen   : inst_sram_wen)   : 4'd0;
  assign mem_addr  = mem_en ? (gnt ? data_sram_addr  : inst_sram_addr)  : 32'd0;
  assign mem_wdata = mem_en ? (gnt ? data_sram_wdata : inst_sram_wdata) : 32'd0;

  assign push = mem_en & mem_addr_ok;
  assign pop  = mem_data_ok & ~empty & ~reset;
  assign head = tag_q[rptr_q];

  assign inst_sram_addr_ok = push & (gnt == INST);
  assign data_sram_addr_ok = push & (gnt == DATA);
  assign inst_sram_data_ok = pop & (head == INST);
  assign data_sram_data_ok = pop & (head == DATA);
  assign inst_sram_rdata   = reset ? 32'd0 : mem_rdata;
  assign data_sram_rdata   = reset ? 32'd0 : mem_rdata;
  assign arb_err           = err_q;

  always_comb begin
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    lock_d  = lock_q;
    owner_d = owner_q;
    // A stalled request pins the port to its master until the address is taken.
    if (mem_en && !mem_addr_ok) begin
      lock_d  = 1'b1;
      owner_d = gnt;
    end else if (push) begin
      lock_d  = 1'b0;
    end
    err_d = err_q | (mem_data_ok & empty);
`ifdef ARB_RR_EN
    last_d = push ? gnt : last_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      lock_q  <= 1'b0;
      owner_q <= INST;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wptr_q] <= gnt;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= INST;
    else       last_q <= last_d;
  end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench for sram_like_arbiter: a queue-based reference model predicts
// grants and response owners; a negedge monitor scores every returned response.
module tb_sram_like_arbiter;
  localparam int OT = 2;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        data_sram_en, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        mem_en, mem_wr, mem_addr_ok, mem_data_ok, arb_err;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  sram_like_arbiter #(.OT_DEPTH(OT)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
  typedef struct {
    bit          own;
    logic [31:0] rd;
  } rsp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   tags[$];
  rsp_t sb[$];
  bit   m_lock, m_owner, m_last, m_err;
  bit   ipend, dpend;
  req_t ireq, dreq;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.wr    = 1'($urandom_range(1));
    r.size  = 2'($urandom_range(2));
    r.wen   = 4'($urandom);
    r.addr  = $urandom;
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic drive_masters();
    inst_sram_en = ipend; {inst_sram_wr, inst_sram_size, inst_sram_wen, inst_sram_addr, inst_sram_wdata} = ireq;
    data_sram_en = dpend; {data_sram_wr, data_sram_size, data_sram_wen, data_sram_addr, data_sram_wdata} = dreq;
  endtask

  task automatic clear_model();
    tags.delete(); sb.delete();
    m_lock = 0; m_owner = 0; m_last = 0; m_err = 0; ipend = 0; dpend = 0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_mem_en"}, 64'(mem_en), 64'd0);
    chk({nm, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({nm, "_addr_ok"}, 64'({inst_sram_addr_ok, data_sram_addr_ok}), 64'd0);
    chk({nm, "_data_ok"}, 64'({inst_sram_data_ok, data_sram_data_ok}), 64'd0);
    chk({nm, "_rdata"}, {inst_sram_rdata, data_sram_rdata}, 64'd0);
    chk({nm, "_arb_err"}, 64'(arb_err), 64'd0);
  endtask

  // Reset asserted between clock edges with every request input active.
  task automatic async_reset(input string nm);
    @(posedge clk); #2;
    inst_sram_en = 1; data_sram_en = 1; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h3c080001;
    reset = 1'b1;
    clear_model();
    #1 chk_all_zero(nm);
    @(posedge clk); #1;
    chk_all_zero({nm, "_held"});
    inst_sram_en = 0; data_sram_en = 0; mem_addr_ok = 0; mem_data_ok = 0;
    reset = 1'b0;
  endtask

  // One cycle: drive at +1, check combinational outputs at +4, then advance the model.
  task automatic step(input int p_req, input int p_aok, input int p_dok, input bit inj_err);
    bit g, gen, e_men, aok, hs, dok, err_nx, full;
    @(posedge clk); #1;
    if (!ipend && $urandom_range(99) < p_req) begin ipend = 1; ireq = rand_req(); end
    if (!dpend && $urandom_range(99) < p_req) begin dpend = 1; dreq = rand_req(); end
    drive_masters();
    full = (tags.size() >= OT);
    if (m_lock)             g = m_owner;
    else if (ipend && dpend) g = RR ? !m_last : 1'b1;
    else                     g = dpend;
    gen   = g ? dpend : ipend;
    e_men = gen && !full;
    aok   = e_men && ($urandom_range(99) < p_aok);
    hs    = aok;
    mem_addr_ok = aok;
    dok = (tags.size() > 0 && $urandom_range(99) < p_dok) || (inj_err && tags.size() == 0);
    mem_data_ok = dok;
    mem_rdata   = $urandom;
    err_nx = 0;
    if (dok && tags.size() > 0) begin
      rsp_t r;
      r.own = tags.pop_front();
      r.rd  = mem_rdata;
      sb.push_back(r);
    end else if (dok) err_nx = 1;
    #3;
    chk("mem_en", 64'(mem_en), 64'(e_men));
    chk("inst_addr_ok", 64'(inst_sram_addr_ok), 64'(hs && !g));
    chk("data_addr_ok", 64'(data_sram_addr_ok), 64'(hs && g));
    chk("arb_err", 64'(arb_err), 64'(m_err));
    if (e_men) begin
      req_t w;
      w = g ? dreq : ireq;
      chk("mem_addr", 64'(mem_addr), 64'(w.addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(w.wdata));
      chk("mem_ctl", 64'({mem_wr, mem_size, mem_wen}), 64'({w.wr, w.size, w.wen}));
    end
    if (e_men && !aok) begin m_lock = 1; m_owner = g; end
    else if (hs) m_lock = 0;
    if (hs) begin
      tags.push_back(g);
      m_last = g;
      if (g) dpend = 0; else ipend = 0;
    end
    m_err = m_err | err_nx;
  endtask

  task automatic run(input int n, input int p_req, input int p_aok, input int p_dok, input bit inj);
    for (int i = 0; i < n; i++) step(p_req, p_aok, p_dok, inj);
  endtask

  // Scoreboard: every response the model released this cycle must appear now, at its owner.
  always @(negedge clk) begin
    if (!reset && (inst_sram_data_ok || data_sram_data_ok || sb.size() != 0)) begin
      if (inst_sram_data_ok && data_sram_data_ok) begin
        chk("both_data_ok", 64'd1, 64'd0);
      end else if (inst_sram_data_ok || data_sram_data_ok) begin
        if (sb.size() == 0) chk("unexpected_data_ok", 64'({inst_sram_data_ok, data_sram_data_ok}), 64'd0);
        else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_owner", 64'(data_sram_data_ok), 64'(e.own));
          chk("rsp_rdata", 64'(data_sram_data_ok ? data_sram_rdata : inst_sram_rdata), 64'(e.rd));
        end
      end
      if (sb.size() != 0) begin
        chk("missing_data_ok", 64'(sb.size()), 64'd0);
        sb.delete();
      end
    end
  end

  initial begin
    ireq = '0; dreq = '0;
    clear_model();
    drive_masters();
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    reset = 1'b1;
    async_reset("reset");
    run(300, 50, 70, 40, 0);
    run(200, 90, 100, 30, 0);
    run(200, 60, 20, 50, 0);
    run(100, 80, 90, 0, 0);
    run(150, 80, 60, 60, 0);
    async_reset("mid_reset");
    run(200, 70, 70, 50, 0);
    run(20, 0, 100, 100, 0);
    run(5, 0, 100, 0, 1);
    run(5, 0, 100, 0, 0);
    async_reset("err_clear");
    run(100, 60, 70, 50, 0);
    run(20, 0, 100, 100, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
